// File: rtl/fp_pkg.sv
// Shared floating-point definitions: class encodings and a width-generic classifier
// reused by every block that inspects packed FP operands.
package fp_pkg;

   localparam logic [2:0] CLS_NORMAL  = 3'd0;
   localparam logic [2:0] CLS_ZERO    = 3'd1;
   localparam logic [2:0] CLS_SUBNORM = 3'd2;
   localparam logic [2:0] CLS_INF     = 3'd3;
   localparam logic [2:0] CLS_QNAN    = 3'd4;
   localparam logic [2:0] CLS_SNAN    = 3'd5;

   localparam int FP_MAX_W = 64;

   // Fields arrive zero-extended to FP_MAX_W; exp_w/mant_w select the live bits.
   function automatic logic [2:0] classify(input logic [FP_MAX_W-1:0] i_exp,
                                           input logic [FP_MAX_W-1:0] i_mant,
                                           input int                  exp_w,
                                           input int                  mant_w);
      logic [FP_MAX_W-1:0] w_emask;
      logic [FP_MAX_W-1:0] w_mmask;
      logic                w_exp_zero;
      logic                w_exp_ones;
      logic                w_mant_zero;
      logic                w_mant_msb;
      w_emask     = (64'd1 << exp_w) - 64'd1;
      w_mmask     = (64'd1 << mant_w) - 64'd1;
      w_exp_zero  = (i_exp & w_emask) == '0;
      w_exp_ones  = (i_exp & w_emask) == w_emask;
      w_mant_zero = (i_mant & w_mmask) == '0;
      w_mant_msb  = ((i_mant >> (mant_w - 1)) & 64'd1) != '0;
      if (w_exp_zero)
         classify = w_mant_zero ? CLS_ZERO : CLS_SUBNORM;
      else if (w_exp_ones) begin
         if (w_mant_zero)
            classify = CLS_INF;
         else
            classify = w_mant_msb ? CLS_QNAN : CLS_SNAN;
      end else
         classify = CLS_NORMAL;
   endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and an exact occupancy count.
// A push is accepted while full only when a pop frees the head in the same cycle.
module fp_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [WIDTH-1:0]             i_wdata,
   output logic [WIDTH-1:0]             o_rdata,
   output logic [$clog2(DEPTH+1)-1:0]   o_level,
   output logic                         o_full,
   output logic                         o_empty
);
   import fp_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign o_empty = (r_level == '0);
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_rdata = r_mem[r_rd_ptr];
   assign o_level = r_level;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/fp_load_queue.sv
// Captures packed FP words (edge- or level-triggered), classifies them and queues
// {sign, exp, mant, cls} for the FP datapath over a valid/ready handshake.
module fp_load_queue #(
   parameter int EXP_W  = 5,
   parameter int MANT_W = 10,
   parameter int DEPTH  = 4,
   parameter int MODE   = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic [EXP_W+MANT_W:0]        data,
   input  logic                         out_ready,
   output logic                         sign,
   output logic [EXP_W-1:0]             exp,
   output logic [MANT_W-1:0]            mant,
   output logic [2:0]                   cls,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         drop
);
   import fp_pkg::*;

   localparam int ENTRY_W = EXP_W + MANT_W + 4;

   logic               r_prev_en;
   logic               r_drop;
   logic [ENTRY_W-1:0] r_last;
   logic               w_capture;
   logic               w_push;
   logic               w_pop;
   logic               w_empty;
   logic [2:0]         w_cls;
   logic [ENTRY_W-1:0] w_entry;
   logic [ENTRY_W-1:0] w_head;

   assign w_capture = (MODE == 1) ? enable : (enable & ~r_prev_en);
   assign w_cls     = classify(FP_MAX_W'(data[EXP_W+MANT_W-1:MANT_W]),
                               FP_MAX_W'(data[MANT_W-1:0]), EXP_W, MANT_W);
   assign w_entry   = {data, w_cls};
   assign valid     = ~w_empty;
   assign w_pop     = valid & out_ready;
   assign w_push    = w_capture & (~full | w_pop);

   fp_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_entry),
      .o_rdata (w_head),
      .o_level (level),
      .o_full  (full),
      .o_empty (w_empty)
   );

   // Once drained, the head slot goes stale; r_last keeps the last popped entry visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_en <= 1'b0;
         r_drop    <= 1'b0;
         r_last    <= '0;
      end else begin
         r_prev_en <= enable;
         r_drop    <= w_capture & full & ~w_pop;
         if (w_pop)
            r_last <= w_head;
      end
   end

   assign drop = r_drop;
   assign {sign, exp, mant, cls} = valid ? w_head : r_last;

endmodule

// File: tb/tb_fp_load_queue.sv
// Bench for fp_load_queue: MODE0/MODE1 default-width instances checked against a
// shift-array queue model every cycle, plus a 32-bit instance checked directly.
module tb_fp_load_queue;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        en0 = 0, rdy0 = 0, en1 = 0, rdy1 = 0, en2 = 0, rdy2 = 0;
   logic [15:0] data0 = '0, data1 = '0;
   logic [31:0] data2 = '0;

   logic        sign0, sign1, sign2;
   logic [4:0]  exp0, exp1;
   logic [7:0]  exp2;
   logic [9:0]  mant0, mant1;
   logic [22:0] mant2;
   logic [2:0]  cls0, cls1, cls2;
   logic        valid0, valid1, valid2, full0, full1, full2, drop0, drop1, drop2;
   logic [2:0]  level0, level1, level2;

   fp_load_queue #(.EXP_W(5), .MANT_W(10), .DEPTH(4), .MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .enable(en0), .data(data0), .out_ready(rdy0),
      .sign(sign0), .exp(exp0), .mant(mant0), .cls(cls0), .valid(valid0),
      .level(level0), .full(full0), .drop(drop0));

   fp_load_queue #(.EXP_W(5), .MANT_W(10), .DEPTH(4), .MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .enable(en1), .data(data1), .out_ready(rdy1),
      .sign(sign1), .exp(exp1), .mant(mant1), .cls(cls1), .valid(valid1),
      .level(level1), .full(full1), .drop(drop1));

   fp_load_queue #(.EXP_W(8), .MANT_W(23), .DEPTH(4), .MODE(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .enable(en2), .data(data2), .out_ready(rdy2),
      .sign(sign2), .exp(exp2), .mant(mant2), .cls(cls2), .valid(valid2),
      .level(level2), .full(full2), .drop(drop2));

   logic        act_valid [2];
   logic        act_full  [2];
   logic        act_drop  [2];
   logic [2:0]  act_level [2];
   logic [18:0] act_head  [2];
   assign act_valid[0] = valid0;  assign act_valid[1] = valid1;
   assign act_full[0]  = full0;   assign act_full[1]  = full1;
   assign act_drop[0]  = drop0;   assign act_drop[1]  = drop1;
   assign act_level[0] = level0;  assign act_level[1] = level1;
   assign act_head[0]  = {sign0, exp0, mant0, cls0};
   assign act_head[1]  = {sign1, exp1, mant1, cls1};

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Reference model: entries kept oldest-first in a small array, shifted on pop.
   logic [18:0] mq    [2][4];
   int          mcnt  [2];
   logic        mprev [2];
   logic        mdrop [2];
   logic [18:0] mlast [2];

   function automatic logic [2:0] ref_cls(input logic [15:0] d);
      int e, m;
      e = int'(d[14:10]);
      m = int'(d[9:0]);
      if (e == 0)  return (m == 0) ? 3'd1 : 3'd2;
      if (e == 31) begin
         if (m == 0)    return 3'd3;
         if (m >= 512)  return 3'd4;
         return 3'd5;
      end
      return 3'd0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; mprev[k] = 0; mdrop[k] = 0; mlast[k] = '0;
      end
   endtask

   task automatic model_step(input int k, input logic en, input logic [15:0] d,
                             input logic rdy, input int mode);
      bit cap, pop;
      int sz;
      sz  = mcnt[k];
      cap = (mode == 1) ? en : (en && !mprev[k]);
      pop = (sz > 0) && rdy;
      mdrop[k] = cap && (sz == 4) && !pop;
      if (pop) begin
         mlast[k] = mq[k][0];
         for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
         mcnt[k]--;
      end
      if (cap && !mdrop[k]) begin
         mq[k][mcnt[k]] = {d, ref_cls(d)};
         mcnt[k]++;
      end
      mprev[k] = en;
   endtask

   task automatic compare(input int k);
      logic        ev;
      logic [18:0] eh;
      ev = mcnt[k] > 0;
      eh = ev ? mq[k][0] : mlast[k];
      chk($sformatf("m%0d valid", k), 32'(act_valid[k]), 32'(ev));
      chk($sformatf("m%0d level", k), 32'(act_level[k]), 32'(mcnt[k]));
      chk($sformatf("m%0d full",  k), 32'(act_full[k]),  32'(mcnt[k] == 4));
      chk($sformatf("m%0d drop",  k), 32'(act_drop[k]),  32'(mdrop[k]));
      chk($sformatf("m%0d head",  k), 32'(act_head[k]),  32'(eh));
   endtask

   task automatic cycle();
      model_step(0, en0, data0, rdy0, 0);
      model_step(1, en1, data1, rdy1, 1);
      @(posedge clk);
      @(negedge clk);
      compare(0);
      compare(1);
   endtask

   typedef struct {
      logic [15:0] data;
      logic        sign;
      logic [4:0]  exp;
      logic [9:0]  mant;
      logic [2:0]  cls;
   } vec_t;

   vec_t        vecs [10];
   logic [15:0] pat  [5];
   logic [2:0]  pcls [4];

   initial begin
      vecs[0] = '{16'h3C00, 1'b0, 5'd15, 10'h000, 3'd0};
      vecs[1] = '{16'h8000, 1'b1, 5'd0,  10'h000, 3'd1};
      vecs[2] = '{16'h0001, 1'b0, 5'd0,  10'h001, 3'd2};
      vecs[3] = '{16'h7C00, 1'b0, 5'd31, 10'h000, 3'd3};
      vecs[4] = '{16'h7E00, 1'b0, 5'd31, 10'h200, 3'd4};
      vecs[5] = '{16'h7D00, 1'b0, 5'd31, 10'h100, 3'd5};
      vecs[6] = '{16'hFC00, 1'b1, 5'd31, 10'h000, 3'd3};
      vecs[7] = '{16'hC000, 1'b1, 5'd16, 10'h000, 3'd0};
      vecs[8] = '{16'h7FFF, 1'b0, 5'd31, 10'h3FF, 3'd4};
      vecs[9] = '{16'h83FF, 1'b1, 5'd0,  10'h3FF, 3'd2};
      pat[0] = 16'h8000; pat[1] = 16'h0001; pat[2] = 16'h7C00;
      pat[3] = 16'h7E00; pat[4] = 16'h7D00;
      pcls[0] = 3'd1; pcls[1] = 3'd2; pcls[2] = 3'd3; pcls[3] = 3'd4;

      // Reset state
      #1 rst_n = 1'b0;
      model_reset();
      #2;
      compare(0);
      compare(1);
      chk("reset valid2", 32'(valid2), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Enable held for 3 cycles: exactly one capture, popped immediately
      en0 = 1; data0 = 16'h3C00; rdy0 = 1;
      cycle();
      chk("t1 valid", 32'(valid0), 32'd1);
      chk("t1 head", 32'(act_head[0]), 32'({1'b0, 5'd15, 10'd0, 3'd0}));
      cycle();
      chk("t1 valid off", 32'(valid0), 32'd0);
      cycle();
      chk("t1 level", 32'(level0), 32'd0);
      en0 = 0; rdy0 = 0;
      cycle();

      // Classification table
      for (int i = 0; i < 10; i++) begin
         en0 = 1; data0 = vecs[i].data; rdy0 = 0;
         cycle();
         chk($sformatf("vec%0d fields", i), 32'(act_head[0]),
             32'({vecs[i].sign, vecs[i].exp, vecs[i].mant, vecs[i].cls}));
         en0 = 0; rdy0 = 1;
         cycle();
         rdy0 = 0;
      end

      // Overflow: fifth capture dropped for one cycle
      rdy0 = 0;
      for (int i = 0; i < 5; i++) begin
         en0 = 1; data0 = pat[i];
         cycle();
         if (i == 4) begin
            chk("ovf drop", 32'(drop0), 32'd1);
            chk("ovf level", 32'(level0), 32'd4);
         end else
            chk("fill level", 32'(level0), 32'(i + 1));
         en0 = 0;
         cycle();
         if (i == 3) chk("fill full", 32'(full0), 32'd1);
         if (i == 4) chk("ovf drop pulse", 32'(drop0), 32'd0);
      end
      rdy0 = 1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain%0d cls", i), 32'(cls0), 32'(pcls[i]));
         if (i == 0) chk("drain0 sign", 32'(sign0), 32'd1);
         cycle();
      end
      chk("drain empty", 32'(valid0), 32'd0);
      rdy0 = 0;

      // MODE1 full FIFO with simultaneous push and pop
      en1 = 1; rdy1 = 0;
      for (int i = 0; i < 4; i++) begin
         data1 = 16'h3C00 + 16'(i);
         cycle();
      end
      chk("m1 full", 32'(full1), 32'd1);
      rdy1 = 1;
      for (int i = 0; i < 6; i++) begin
         data1 = 16'h3C04 + 16'(i);
         cycle();
         chk("m1 no drop", 32'(drop1), 32'd0);
         chk("m1 level", 32'(level1), 32'd4);
         chk("m1 head mant", 32'(mant1), 32'(i + 1));
      end
      en1 = 0;
      for (int i = 0; i < 4; i++) cycle();
      rdy1 = 0;
      cycle();

      // Asynchronous reset between clock edges with level=3
      for (int i = 0; i < 3; i++) begin
         en0 = 1; data0 = 16'h4000 + 16'(i);
         cycle();
         en0 = 0;
         cycle();
      end
      chk("pre-reset level", 32'(level0), 32'd3);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("async valid", 32'(valid0), 32'd0);
      chk("async level", 32'(level0), 32'd0);
      chk("async full", 32'(full0), 32'd0);
      chk("async fields", 32'(act_head[0]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      en0 = 1; data0 = 16'hC000;
      cycle();
      chk("post-reset head", 32'(act_head[0]), 32'({1'b1, 5'd16, 10'd0, 3'd0}));
      en0 = 0; rdy0 = 1;
      cycle();
      rdy0 = 0;

      // 32-bit instance
      en2 = 1; data2 = 32'h7F800001;
      cycle();
      chk("w32 snan cls", 32'(cls2), 32'd5);
      chk("w32 snan exp", 32'(exp2), 32'hFF);
      chk("w32 snan mant", 32'(mant2), 32'h1);
      en2 = 0; rdy2 = 1;
      cycle();
      chk("w32 popped", 32'(valid2), 32'd0);
      rdy2 = 0; en2 = 1; data2 = 32'h3F800000;
      cycle();
      chk("w32 norm cls", 32'(cls2), 32'd0);
      chk("w32 norm exp", 32'(exp2), 32'd127);
      chk("w32 norm mant", 32'(mant2), 32'd0);
      en2 = 0; rdy2 = 1;
      cycle();
      rdy2 = 0;

      // Stall stability, then ready while empty
      en0 = 1; data0 = 16'h7E00; rdy0 = 0;
      cycle();
      en0 = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall head", 32'(act_head[0]), 32'({1'b0, 5'd31, 10'h200, 3'd4}));
      end
      rdy0 = 1;
      cycle();
      chk("last held", 32'(act_head[0]), 32'({1'b0, 5'd31, 10'h200, 3'd4}));
      cycle();
      cycle();
      chk("empty ready level", 32'(level0), 32'd0);
      chk("empty ready valid", 32'(valid0), 32'd0);
      rdy0 = 0;

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [15:0] d;
         en0  = 1'($urandom_range(0, 1));
         en1  = ($urandom_range(0, 2) != 0);
         rdy0 = ($urandom_range(0, 2) == 0);
         rdy1 = ($urandom_range(0, 2) == 0);
         for (int k = 0; k < 2; k++) begin
            d = 16'($urandom);
            case ($urandom_range(0, 3))
               0:       d[14:10] = 5'd0;
               1:       d[14:10] = 5'd31;
               default: ;
            endcase
            if (k == 0) data0 = d; else data1 = d;
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
